// File: rtl/mips_pkg.sv
// Shared arbiter types: FSM state codes, grant encoding and default latency.
// Imported by the memory port arbiter and its grant selector.
package mips_pkg;

    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE   = 2'd0;
    localparam arb_state_t ACCESS = 2'd1;
    localparam arb_state_t RESP   = 2'd2;

    localparam logic GRANT_IF = 1'b0;
    localparam logic GRANT_DM = 1'b1;

    localparam int MEM_LAT_DEF = 2;
    localparam int CNT_W       = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline/memory bundle for the shared memory port arbiter.
// slave = arbiter side, master = pipeline plus memory macro side.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;

    logic              stall_f;
    logic              stall_m;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req,
        input  if_addr,
        output if_rdata,
        output if_ready,
        input  dm_req,
        input  dm_we,
        input  dm_addr,
        input  dm_wdata,
        output dm_rdata,
        output dm_ready,
        output stall_f,
        output stall_m,
        output mem_en,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport master (
        output if_req,
        output if_addr,
        input  if_rdata,
        input  if_ready,
        output dm_req,
        output dm_we,
        output dm_addr,
        output dm_wdata,
        input  dm_rdata,
        input  dm_ready,
        input  stall_f,
        input  stall_m,
        input  mem_en,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_grant_sel.sv
// Combinational winner selection between fetch and data requests.
// ARB_ROUND_ROBIN_EN: ties alternate against last_grant; else dm wins ties.
module arb_grant_sel
    import mips_pkg::*;
(
    input  logic if_req_i,
    input  logic dm_req_i,
`ifdef ARB_ROUND_ROBIN_EN
    input  logic last_grant_i,
`endif
    output logic valid_o,
    output logic grant_o
);

    logic tie_grant;

`ifdef ARB_ROUND_ROBIN_EN
    assign tie_grant = ~last_grant_i;
`else
    assign tie_grant = GRANT_DM;
`endif

    always_comb begin
        valid_o = if_req_i | dm_req_i;
        grant_o = GRANT_IF;
        unique case (1'b1)
            (if_req_i & dm_req_i):  grant_o = tie_grant;
            (dm_req_i & ~if_req_i): grant_o = GRANT_DM;
            default:                grant_o = GRANT_IF;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between IF and DM with per-stage stalls.
// ARB_ROUND_ROBIN_EN: round-robin tie-break instead of fixed dm priority.
module mem_port_arbiter
    import mips_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_chk
        $error("MEM_LAT out of range 1..15");
    end

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

    logic sel_valid;
    logic sel_grant;
    logic mem_en_w;
    logic if_ready_w;
    logic dm_ready_w;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_q, last_grant_d;
`endif

    arb_grant_sel u_sel (
        .if_req_i     (bus.if_req),
        .dm_req_i     (bus.dm_req),
`ifdef ARB_ROUND_ROBIN_EN
        .last_grant_i (last_grant_q),
`endif
        .valid_o      (sel_valid),
        .grant_o      (sel_grant)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
`endif
        unique case (1'b1)
            (state_q == IDLE): begin
                if (sel_valid) begin
                    grant_d = sel_grant;
                    cnt_d   = ONE_C;
                    state_d = ACCESS;
                    if (sel_grant == GRANT_DM) begin
                        addr_d  = bus.dm_addr;
                        we_d    = bus.dm_we;
                        wdata_d = bus.dm_wdata;
                    end else begin
                        addr_d  = bus.if_addr;
                        we_d    = 1'b0;
                        wdata_d = '0;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_grant_d = sel_grant;
`endif
                end
            end
            (state_q == ACCESS): begin
                cnt_d = cnt_q + ONE_C;
                if (cnt_q == LAT_C) begin
                    state_d = RESP;
                    if (grant_q == GRANT_DM) begin
                        dm_rdata_d = bus.mem_rdata;
                    end else begin
                        if_rdata_d = bus.mem_rdata;
                    end
                end
            end
            (state_q == RESP): begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            grant_q    <= GRANT_IF;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_IF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Strobe only on the first access cycle; later cycles wait out latency.
    assign mem_en_w   = (state_q == ACCESS) && (cnt_q == ONE_C);
    assign if_ready_w = (state_q == RESP) && (grant_q == GRANT_IF);
    assign dm_ready_w = (state_q == RESP) && (grant_q == GRANT_DM);

    assign bus.mem_en    = mem_en_w;
    assign bus.mem_we    = mem_en_w & we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign bus.if_ready = if_ready_w;
    assign bus.dm_ready = dm_ready_w;
    assign bus.if_rdata = if_rdata_q;
    assign bus.dm_rdata = dm_rdata_q;

    assign bus.stall_f = bus.if_req & ~if_ready_w;
    assign bus.stall_m = bus.dm_req & ~dm_ready_w;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a timeline reference model.
// Also runs a directed MEM_LAT=1 instance.
module tb_mem_port_arbiter;

    localparam int LAT  = 2;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    logic rst;
    logic rst1;

    always #5 clk = ~clk;

    mem_port_arbiter_if m ();
    mem_port_arbiter_if m1 ();

    mem_port_arbiter #(.MEM_LAT(LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    mem_port_arbiter #(.MEM_LAT(1)) dut1 (
        .clk (clk),
        .rst (rst1),
        .bus (m1)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] f(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h2008_0005;
    endfunction

    // Memory macro: data appears in the LAT-th cycle of an access.
    logic [31:0] dev_mem [0:255];
    logic        mem_init = 1'b0;
    logic [3:0]  age = 4'd0;
    logic [31:0] rdat = 32'h0;

    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 256; i++) dev_mem[i] <= f(32'(i) << 2);
            mem_init <= 1'b1;
        end
        if (m.mem_en) begin
            age <= 4'd2;
            if (m.mem_we) dev_mem[m.mem_addr[9:2]] <= m.mem_wdata;
            else          rdat <= dev_mem[m.mem_addr[9:2]];
        end else if (age != 4'd0 && age != 4'd15) begin
            age <= age + 4'd1;
        end
    end

    assign m.mem_rdata  = (int'(age) == LAT) ? rdat : 32'hBAD0_BAD0;
    assign m1.mem_rdata = m1.mem_en ? f(m1.mem_addr) : 32'hBAD0_BAD0;

    logic [31:0] ref_mem [0:255];

    int          cyc;
    bit          act;
    bit          g;
    int          tg;
    int          free_at;
    bit          last_g;
    logic [31:0] ga, gw, exp_d;
    bit          gwe;
    int          n_rst;

    bit          ifr, dmr, dmwe;
    logic [31:0] ifa, dma, dmd;
    bit          if_gr, dm_gr, if_done, dm_done;

    task automatic check_zero(input string p);
        check({p, "_mem_en"}, 32'(m.mem_en), 32'h0);
        check({p, "_mem_we"}, 32'(m.mem_we), 32'h0);
        check({p, "_mem_addr"}, m.mem_addr, 32'h0);
        check({p, "_mem_wdata"}, m.mem_wdata, 32'h0);
        check({p, "_if_ready"}, 32'(m.if_ready), 32'h0);
        check({p, "_dm_ready"}, 32'(m.dm_ready), 32'h0);
        check({p, "_if_rdata"}, m.if_rdata, 32'h0);
        check({p, "_dm_rdata"}, m.dm_rdata, 32'h0);
    endtask

    function automatic logic [31:0] raddr();
        return 32'($urandom_range(0, 255)) << 2;
    endfunction

    initial begin
        bit hi, dropped, exp_en, exp_ir, exp_dr, w;
        rst = 1'b1;
        m.if_req = 0; m.if_addr = 0;
        m.dm_req = 0; m.dm_we = 0; m.dm_addr = 0; m.dm_wdata = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = f(32'(i) << 2);
        act = 0; free_at = 0; last_g = 0; n_rst = 0;
        ifr = 0; dmr = 0; dmwe = 0; ifa = 0; dma = 0; dmd = 0;
        if_gr = 0; dm_gr = 0; if_done = 0; dm_done = 0;
        #2;
        check_zero("reset");
        @(posedge clk);
        for (int n = 0; n < NCYC; n++) begin
            @(posedge clk);
            #1;
            if (rst) rst = 1'b0;
            cyc = n;
            hi = (n < 400);
            if (if_done) begin ifr = 0; if_done = 0; end
            if (dm_done) begin dmr = 0; dm_done = 0; end
            dropped = 0;
            if (ifr && !if_gr && $urandom_range(0, 15) == 0) begin
                ifr = 0; dropped = 1;
            end
            if (!ifr && !dropped && (hi || $urandom_range(0, 1) == 1)) begin
                ifr = 1; ifa = raddr();
            end
            dropped = 0;
            if (dmr && !dm_gr && $urandom_range(0, 15) == 0) begin
                dmr = 0; dropped = 1;
            end
            if (!dmr && !dropped && (hi || $urandom_range(0, 2) == 0)) begin
                dmr = 1; dma = raddr();
                dmwe = ($urandom_range(0, 1) == 1); dmd = $urandom;
            end
            m.if_req = ifr; m.if_addr = ifa;
            m.dm_req = dmr; m.dm_we = dmwe;
            m.dm_addr = dma; m.dm_wdata = dmd;

            @(negedge clk);
            exp_en = act && (cyc == tg + 1);
            exp_ir = act && !g && (cyc == tg + LAT + 1);
            exp_dr = act && g && (cyc == tg + LAT + 1);
            check("mem_en", 32'(m.mem_en), 32'(exp_en));
            check("if_ready", 32'(m.if_ready), 32'(exp_ir));
            check("dm_ready", 32'(m.dm_ready), 32'(exp_dr));
            check("stall_f", 32'(m.stall_f), 32'(ifr & ~exp_ir));
            check("stall_m", 32'(m.stall_m), 32'(dmr & ~exp_dr));
            if (exp_en) begin
                check("mem_addr", m.mem_addr, ga);
                check("mem_we", 32'(m.mem_we), 32'(gwe));
                if (gwe) check("mem_wdata", m.mem_wdata, gw);
            end
            if (exp_ir) begin
                check("if_rdata", m.if_rdata, exp_d);
                if_done = 1; if_gr = 0; act = 0;
            end
            if (exp_dr) begin
                if (!gwe) check("dm_rdata", m.dm_rdata, exp_d);
                dm_done = 1; dm_gr = 0; act = 0;
            end
            if (exp_en && !gwe && cyc > 600 && n_rst < 3 &&
                $urandom_range(0, 3) == 0) begin
                rst = 1'b1;
                #1;
                check_zero("midrst");
                act = 0; free_at = cyc + 1; last_g = 0;
                if_gr = 0; dm_gr = 0; n_rst++;
            end else if (cyc >= free_at && (ifr || dmr)) begin
`ifdef ARB_ROUND_ROBIN_EN
                if (ifr && dmr) w = ~last_g;
                else            w = dmr;
`else
                w = dmr;
`endif
                last_g = w; act = 1; g = w; tg = cyc;
                free_at = cyc + LAT + 2;
                if (w) begin
                    ga = dma; gwe = dmwe; gw = dmd; dm_gr = 1;
                    if (dmwe) ref_mem[dma[9:2]] = dmd;
                    else      exp_d = ref_mem[dma[9:2]];
                end else begin
                    ga = ifa; gwe = 0; gw = 0; if_gr = 1;
                    exp_d = ref_mem[ifa[9:2]];
                end
            end
        end
        check("reset_pulses", 32'(n_rst > 0), 32'h1);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        rst1 = 1'b1;
        m1.if_req = 0; m1.if_addr = 0;
        m1.dm_req = 0; m1.dm_we = 0; m1.dm_addr = 0; m1.dm_wdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst1 = 1'b0;
        m1.if_req = 1; m1.if_addr = 32'h40;
        @(negedge clk);
        check("l1_c0_en", 32'(m1.mem_en), 32'h0);
        check("l1_c0_stall", 32'(m1.stall_f), 32'h1);
        @(negedge clk);
        check("l1_c1_en", 32'(m1.mem_en), 32'h1);
        check("l1_c1_addr", m1.mem_addr, 32'h40);
        check("l1_c1_rdy", 32'(m1.if_ready), 32'h0);
        @(negedge clk);
        check("l1_c2_rdy", 32'(m1.if_ready), 32'h1);
        check("l1_c2_data", m1.if_rdata, f(32'h40));
        check("l1_c2_stall", 32'(m1.stall_f), 32'h0);
        check("l1_c2_en", 32'(m1.mem_en), 32'h0);
        @(posedge clk);
        #1;
        m1.if_req = 0;
        m1.dm_req = 1; m1.dm_addr = 32'h100;
        @(negedge clk);
        check("l1_c3_rdy", 32'(m1.if_ready), 32'h0);
        check("l1_c3_hold", m1.if_rdata, f(32'h40));
        @(negedge clk);
        check("l1_c4_en", 32'(m1.mem_en), 32'h1);
        check("l1_c4_addr", m1.mem_addr, 32'h100);
        @(negedge clk);
        check("l1_c5_rdy", 32'(m1.dm_ready), 32'h1);
        check("l1_c5_data", m1.dm_rdata, f(32'h100));
        check("l1_c5_stall", 32'(m1.stall_m), 32'h0);
        @(posedge clk);
        #1;
        m1.dm_req = 0;
    end

endmodule
